axi_aw_xbar: RTL and testbench

//  Parametrised AXI write-address (AW) crossbar connecting NUM_M masters to NUM_S slaves.
//  - Round-robin arbitration between masters; grant held until the AW handshake completes.
//  - Address decode with a configurable map; unmapped addresses go to the default slave (index NUM_S-1).
//  - Records each accepted burst's {master, slave} pair in a route FIFO, which steers the W and B channels.

---
 rtl/axi_aw_xbar.sv | 182 ++++++++++++++++++
 tb/tb_axi_aw_xbar.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_aw_xbar.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_aw_xbar : round-robin AXI write-address crossbar with W/B route FIFO   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module axi_aw_xbar #(
  parameter int NUM_M     = 2,
  parameter int NUM_S     = 3,
  parameter int ID_BITS   = 4,
  parameter int ADDR_BITS = 32,
  parameter int LEN_BITS  = 4,
  parameter int SIZE_BITS = 3,
  parameter logic [(NUM_S-1)*ADDR_BITS-1:0] S_BASE = {32'h1000_0000, 32'h0000_0000},
  parameter logic [(NUM_S-1)*ADDR_BITS-1:0] S_MASK = {32'hFFFF_0000, 32'hFFFF_0000},
  parameter int WQ_DEPTH  = 4,
  localparam int MI       = (NUM_M > 1) ? $clog2(NUM_M) : 1,
  localparam int SI       = $clog2(NUM_S),
  localparam int IDS_BITS = ID_BITS + MI
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_M*ID_BITS-1:0]   AWID_M,
  input  logic [NUM_M*ADDR_BITS-1:0] AWADDR_M,
  input  logic [NUM_M*LEN_BITS-1:0]  AWLEN_M,
  input  logic [NUM_M*SIZE_BITS-1:0] AWSIZE_M,
  input  logic [NUM_M*2-1:0]         AWBURST_M,
  input  logic [NUM_M-1:0]           AWVALID_M,
  output logic [NUM_M-1:0]           AWREADY_M,
  output logic [IDS_BITS-1:0]        AWID_S,
  output logic [ADDR_BITS-1:0]       AWADDR_S,
  output logic [LEN_BITS-1:0]        AWLEN_S,
  output logic [SIZE_BITS-1:0]       AWSIZE_S,
  output logic [1:0]                 AWBURST_S,
  output logic [NUM_S-1:0]           AWVALID_S,
  input  logic [NUM_S-1:0]           AWREADY_S,
  output logic                       wroute_valid,
  output logic [MI-1:0]              wroute_m,
  output logic [SI-1:0]              wroute_s,
  input  logic                       wroute_pop
);

  localparam int PW = $clog2(WQ_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_grant_load;
  logic [MI-1:0]        r_grant;
  logic [SI-1:0]        r_sel;
  logic [MI-1:0]        r_rr;
  logic [MI-1:0]        w_rr_nxt;
  logic                 w_any;
  logic [MI-1:0]        w_win;
  logic [ADDR_BITS-1:0] w_win_addr;
  logic [SI-1:0]        w_dec;
  logic                 w_hs;

  logic [PW:0]          r_wptr;
  logic [PW:0]          r_rptr;
  logic [MI-1:0]        r_qm [WQ_DEPTH];
  logic [SI-1:0]        r_qs [WQ_DEPTH];
  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;

  // Round-robin scan starting at r_rr
  always_comb begin : p_arb
    int idx;
    idx   = 0;
    w_any = 1'b0;
    w_win = '0;
    for (int k = 0; k < NUM_M; k++) begin
      idx = (int'(r_rr) + k) % NUM_M;
      if (!w_any && AWVALID_M[idx]) begin
        w_any = 1'b1;
        w_win = idx[MI-1:0];
      end
    end
  end

  // Lowest matching window wins; descending scan lets lower indices overwrite
  always_comb begin : p_dec
    w_win_addr = AWADDR_M[int'(w_win)*ADDR_BITS +: ADDR_BITS];
    w_dec      = SI'(NUM_S-1);
    for (int i = NUM_S-2; i >= 0; i--) begin
      if ((w_win_addr & S_MASK[i*ADDR_BITS +: ADDR_BITS]) == S_BASE[i*ADDR_BITS +: ADDR_BITS])
        w_dec = SI'(i);
    end
  end

  assign w_hs     = (r_state == ST_BUSY) && AWVALID_M[r_grant] && AWREADY_S[r_sel];
  assign w_rr_nxt = (r_grant == MI'(NUM_M-1)) ? '0 : r_grant + MI'(1);

  always_comb begin : p_fsm_nxt
    w_state_nxt  = r_state;
    w_grant_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any && !w_full) begin
          w_state_nxt  = ST_BUSY;
          w_grant_load = 1'b1;
        end
      end
      ST_BUSY: begin
        if (w_hs) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant <= '0;
      r_sel   <= '0;
      r_rr    <= '0;
    end else begin
      if (w_grant_load) begin
        r_grant <= w_win;
        r_sel   <= w_dec;
      end
      if (w_hs) r_rr <= w_rr_nxt;
    end
  end

  always_comb begin : p_slave_side
    AWID_S     = '0;
    AWADDR_S   = '0;
    AWLEN_S    = '0;
    AWSIZE_S   = '0;
    AWBURST_S  = '0;
    AWVALID_S  = '0;
    AWREADY_M  = '0;
    if (r_state == ST_BUSY) begin
      AWID_S             = {r_grant, AWID_M[int'(r_grant)*ID_BITS +: ID_BITS]};
      AWADDR_S           = AWADDR_M[int'(r_grant)*ADDR_BITS +: ADDR_BITS];
      AWLEN_S            = AWLEN_M[int'(r_grant)*LEN_BITS +: LEN_BITS];
      AWSIZE_S           = AWSIZE_M[int'(r_grant)*SIZE_BITS +: SIZE_BITS];
      AWBURST_S          = AWBURST_M[int'(r_grant)*2 +: 2];
      AWVALID_S[r_sel]   = AWVALID_M[r_grant];
      AWREADY_M[r_grant] = AWREADY_S[r_sel];
    end
  end

  // Route FIFO: extra pointer MSB distinguishes full from empty
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_pop   = wroute_pop && !w_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int j = 0; j < WQ_DEPTH; j++) begin
        r_qm[j] <= '0;
        r_qs[j] <= '0;
      end
    end else begin
      if (w_hs) begin
        r_qm[r_wptr[PW-1:0]] <= r_grant;
        r_qs[r_wptr[PW-1:0]] <= r_sel;
        r_wptr               <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
    end
  end

  assign wroute_valid = !w_empty;
  assign wroute_m     = w_empty ? '0 : r_qm[r_rptr[PW-1:0]];
  assign wroute_s     = w_empty ? '0 : r_qs[r_rptr[PW-1:0]];

endmodule
`default_nettype wire

// File: tb/tb_axi_aw_xbar.sv
`timescale 1ns/1ps
`default_nettype none
// Self-checking bench for axi_aw_xbar: directed corner sequences, decode table,
// and randomized traffic against a transaction-level reference model.
module tb_axi_aw_xbar;

  localparam int NUM_M = 2;
  localparam int NUM_S = 3;
  localparam int WQ    = 4;
  localparam logic [31:0] MAP_BASE [2] = '{32'h0000_0000, 32'h1000_0000};
  localparam logic [31:0] MAP_MASK [2] = '{32'hFFFF_0000, 32'hFFFF_0000};

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  awid_m;
  logic [63:0] awaddr_m;
  logic [7:0]  awlen_m;
  logic [5:0]  awsize_m;
  logic [3:0]  awburst_m;
  logic [1:0]  awvalid_m;
  logic [1:0]  awready_m;
  logic [4:0]  awid_s;
  logic [31:0] awaddr_s;
  logic [3:0]  awlen_s;
  logic [2:0]  awsize_s;
  logic [1:0]  awburst_s;
  logic [2:0]  awvalid_s;
  logic [2:0]  awready_s;
  logic        wroute_valid;
  logic [0:0]  wroute_m;
  logic [1:0]  wroute_s;
  logic        wroute_pop;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  axi_aw_xbar dut (
    .clk(clk), .rst(rst),
    .AWID_M(awid_m), .AWADDR_M(awaddr_m), .AWLEN_M(awlen_m), .AWSIZE_M(awsize_m),
    .AWBURST_M(awburst_m), .AWVALID_M(awvalid_m), .AWREADY_M(awready_m),
    .AWID_S(awid_s), .AWADDR_S(awaddr_s), .AWLEN_S(awlen_s), .AWSIZE_S(awsize_s),
    .AWBURST_S(awburst_s), .AWVALID_S(awvalid_s), .AWREADY_S(awready_s),
    .wroute_valid(wroute_valid), .wroute_m(wroute_m), .wroute_s(wroute_s),
    .wroute_pop(wroute_pop)
  );

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic [3:0]  id;
    int          sel;
  } vec_t;

  typedef struct {
    int m;
    int s;
  } route_t;

  vec_t   vecs [8];
  route_t q [$];
  int     pend_m, pend_s, rr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_m(input int m, input logic [31:0] a, input logic [3:0] id);
    awaddr_m[m*32 +: 32] = a;
    awid_m[m*4 +: 4]     = id;
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    awvalid_m  = '0;
    awready_s  = '0;
    wroute_pop = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < NUM_S-1; i++)
      if ((a & MAP_MASK[i]) == MAP_BASE[i]) return i;
    return NUM_S-1;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 32'h0000_0010, 4'h1, 0};
    vecs[1] = '{1, 32'h2000_0000, 4'h2, 2};
    vecs[2] = '{1, 32'h1000_0004, 4'h3, 1};
    vecs[3] = '{0, 32'h0000_FFFF, 4'h4, 0};
    vecs[4] = '{0, 32'h0001_0000, 4'h5, 2};
    vecs[5] = '{1, 32'h1000_FFFF, 4'h6, 1};
    vecs[6] = '{0, 32'h1001_0000, 4'h7, 2};
    vecs[7] = '{1, 32'hFFFF_FFFF, 4'h8, 2};

    // Reset held with live requests: outputs must stay zero
    rst        = 1'b0;
    awid_m     = '0;
    awaddr_m   = '0;
    set_m(0, 32'h0000_0010, 4'h5);
    set_m(1, 32'h2000_0000, 4'hA);
    awlen_m    = 8'h73;
    awsize_m   = 6'o52;
    awburst_m  = 4'b1001;
    awvalid_m  = 2'b11;
    awready_s  = 3'b111;
    wroute_pop = 1'b0;
    tick();
    tick();
    mid();
    check("rst_awready_m", 64'(awready_m), 64'h0);
    check("rst_awvalid_s", 64'(awvalid_s), 64'h0);
    check("rst_awaddr_s", 64'(awaddr_s), 64'h0);
    check("rst_awid_s", 64'(awid_s), 64'h0);
    check("rst_wroute_valid", 64'(wroute_valid), 64'h0);
    check("rst_wroute_m", 64'(wroute_m), 64'h0);
    check("rst_wroute_s", 64'(wroute_s), 64'h0);
    tick();
    rst = 1'b1;

    // Both masters requesting, all slaves ready: alternate M0/M1 until FIFO full
    for (int c = 0; c < 11; c++) begin
      logic [1:0] er;
      logic [2:0] ev;
      logic [4:0] eid;
      er  = 2'b00;
      ev  = 3'b000;
      eid = 5'h00;
      if (c < 8 && (c % 2) == 1) begin
        er  = ((c % 4) == 1) ? 2'b01 : 2'b10;
        ev  = ((c % 4) == 1) ? 3'b001 : 3'b100;
        eid = ((c % 4) == 1) ? 5'h05 : 5'h1A;
      end
      mid();
      check("alt_awready_m", 64'(awready_m), 64'(er));
      check("alt_awvalid_s", 64'(awvalid_s), 64'(ev));
      check("alt_awid_s", 64'(awid_s), 64'(eid));
      check("alt_wroute_valid", 64'(wroute_valid), 64'(c >= 2));
      if (c >= 2) begin
        check("alt_head_m", 64'(wroute_m), 64'h0);
        check("alt_head_s", 64'(wroute_s), 64'h0);
      end
      tick();
    end
    wroute_pop = 1'b1;
    mid();
    check("full_awvalid_s", 64'(awvalid_s), 64'h0);
    check("full_awready_m", 64'(awready_m), 64'h0);
    tick();
    wroute_pop = 1'b0;
    mid();
    check("pop1_awvalid_s", 64'(awvalid_s), 64'h0);
    check("pop1_head_m", 64'(wroute_m), 64'h1);
    check("pop1_head_s", 64'(wroute_s), 64'h2);
    tick();
    mid();
    check("regrant_awready_m", 64'(awready_m), 64'h1);
    check("regrant_awvalid_s", 64'(awvalid_s), 64'h1);
    tick();
    awvalid_m = 2'b00;
    for (int i = 0; i < 4; i++) begin
      wroute_pop = 1'b1;
      mid();
      check("drain_valid", 64'(wroute_valid), 64'h1);
      check("drain_head_m", 64'(wroute_m), 64'((i % 2 == 0) ? 1 : 0));
      check("drain_head_s", 64'(wroute_s), 64'((i % 2 == 0) ? 2 : 0));
      tick();
    end
    mid();
    check("pop_empty_valid", 64'(wroute_valid), 64'h0);
    tick();
    wroute_pop = 1'b0;
    mid();
    check("after_empty_pop_valid", 64'(wroute_valid), 64'h0);
    tick();

    // Slave 1 stalls while M0 waits: grant must stay on M1
    set_m(1, 32'h1000_0004, 4'h3);
    awvalid_m = 2'b11;
    awready_s = 3'b101;
    mid();
    check("stall_idle_rdy", 64'(awready_m), 64'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      mid();
      check("stall_awvalid_s", 64'(awvalid_s), 64'h2);
      check("stall_awready_m", 64'(awready_m), 64'h0);
      check("stall_awid_s", 64'(awid_s), 64'h13);
      tick();
    end
    awready_s = 3'b111;
    mid();
    check("stall_release_rdy", 64'(awready_m), 64'h2);
    check("stall_release_vs", 64'(awvalid_s), 64'h2);
    tick();
    mid();
    check("stall_post_vs", 64'(awvalid_s), 64'h0);
    check("stall_head_m", 64'(wroute_m), 64'h1);
    check("stall_head_s", 64'(wroute_s), 64'h1);
    tick();
    mid();
    check("stall_next_m0_rdy", 64'(awready_m), 64'h1);
    check("stall_next_m0_vs", 64'(awvalid_s), 64'h1);
    tick();
    awvalid_m = 2'b00;
    mid();
    check("stall_fifo_valid", 64'(wroute_valid), 64'h1);
    tick();

    // Async reset in the middle of a stalled grant
    awvalid_m = 2'b01;
    awready_s = 3'b000;
    mid();
    tick();
    mid();
    check("prerst_busy_vs", 64'(awvalid_s), 64'h1);
    #1;
    rst = 1'b0;
    awready_s = 3'b111;
    #1;
    check("midrst_awvalid_s", 64'(awvalid_s), 64'h0);
    check("midrst_awready_m", 64'(awready_m), 64'h0);
    check("midrst_awaddr_s", 64'(awaddr_s), 64'h0);
    check("midrst_awid_s", 64'(awid_s), 64'h0);
    check("midrst_wroute_valid", 64'(wroute_valid), 64'h0);
    tick();
    tick();
    rst = 1'b1;
    set_m(1, 32'h2000_0000, 4'hA);
    awvalid_m = 2'b11;
    mid();
    check("restart_idle_rdy", 64'(awready_m), 64'h0);
    tick();
    mid();
    check("restart_grant_m0", 64'(awready_m), 64'h1);
    tick();
    awvalid_m = 2'b00;

    // Decode table, one isolated transaction per entry
    do_reset();
    awready_s = 3'b111;
    for (int v = 0; v < 8; v++) begin
      set_m(vecs[v].m, vecs[v].addr, vecs[v].id);
      awvalid_m = 2'(1 << vecs[v].m);
      mid();
      check("tbl_idle_rdy", 64'(awready_m), 64'h0);
      tick();
      mid();
      check("tbl_awvalid_s", 64'(awvalid_s), 64'(1 << vecs[v].sel));
      check("tbl_awready_m", 64'(awready_m), 64'(1 << vecs[v].m));
      check("tbl_awid_s", 64'(awid_s), 64'((vecs[v].m << 4) | int'(vecs[v].id)));
      check("tbl_awaddr_s", 64'(awaddr_s), 64'(vecs[v].addr));
      tick();
      awvalid_m = 2'b00;
      mid();
      check("tbl_route_valid", 64'(wroute_valid), 64'h1);
      check("tbl_route_m", 64'(wroute_m), 64'(vecs[v].m));
      check("tbl_route_s", 64'(wroute_s), 64'(vecs[v].sel));
      tick();
      wroute_pop = 1'b1;
      mid();
      tick();
      wroute_pop = 1'b0;
      mid();
      check("tbl_route_empty", 64'(wroute_valid), 64'h0);
      tick();
    end

    // Randomized traffic vs transaction-level model
    do_reset();
    pend_m = -1;
    pend_s = 0;
    rr     = 0;
    q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int          old;
      logic [2:0]  ev;
      logic [1:0]  er;
      logic [4:0]  eid;
      logic [31:0] ea;
      logic [3:0]  el;
      logic [2:0]  esz;
      logic [1:0]  eb;
      awvalid_m  = 2'($urandom_range(0, 3));
      awready_s  = 3'($urandom_range(0, 7));
      wroute_pop = ($urandom_range(0, 3) == 0);
      awid_m     = 8'($urandom);
      awlen_m    = 8'($urandom);
      awsize_m   = 6'($urandom);
      awburst_m  = 4'($urandom);
      for (int m = 0; m < NUM_M; m++) begin
        case ($urandom_range(0, 3))
          0:       awaddr_m[m*32 +: 32] = {16'h0000, 16'($urandom)};
          1:       awaddr_m[m*32 +: 32] = {16'h1000, 16'($urandom)};
          2:       awaddr_m[m*32 +: 32] = {16'h1000 ^ 16'(1 << $urandom_range(0, 15)), 16'($urandom)};
          default: awaddr_m[m*32 +: 32] = $urandom;
        endcase
      end
      mid();
      ev = '0; er = '0; eid = '0; ea = '0; el = '0; esz = '0; eb = '0;
      if (pend_m >= 0) begin
        ev  = awvalid_m[pend_m] ? 3'(1 << pend_s) : 3'b000;
        er  = awready_s[pend_s] ? 2'(1 << pend_m) : 2'b00;
        eid = 5'(pend_m * 16 + int'(awid_m[pend_m*4 +: 4]));
        ea  = awaddr_m[pend_m*32 +: 32];
        el  = awlen_m[pend_m*4 +: 4];
        esz = awsize_m[pend_m*3 +: 3];
        eb  = awburst_m[pend_m*2 +: 2];
      end
      check("rnd_awvalid_s", 64'(awvalid_s), 64'(ev));
      check("rnd_awready_m", 64'(awready_m), 64'(er));
      check("rnd_awid_s", 64'(awid_s), 64'(eid));
      check("rnd_awaddr_s", 64'(awaddr_s), 64'(ea));
      check("rnd_awlen_s", 64'(awlen_s), 64'(el));
      check("rnd_awsize_s", 64'(awsize_s), 64'(esz));
      check("rnd_awburst_s", 64'(awburst_s), 64'(eb));
      check("rnd_wroute_valid", 64'(wroute_valid), 64'(q.size() > 0));
      if (q.size() > 0) begin
        check("rnd_wroute_m", 64'(wroute_m), 64'(q[0].m));
        check("rnd_wroute_s", 64'(wroute_s), 64'(q[0].s));
      end
      old = q.size();
      if (pend_m >= 0) begin
        if (awvalid_m[pend_m] && awready_s[pend_s]) begin
          q.push_back('{pend_m, pend_s});
          rr     = (pend_m + 1) % NUM_M;
          pend_m = -1;
        end
      end else if (old < WQ && awvalid_m != 2'b00) begin
        for (int k = 0; k < NUM_M; k++) begin
          int idx;
          idx = (rr + k) % NUM_M;
          if (pend_m < 0 && awvalid_m[idx]) begin
            pend_m = idx;
            pend_s = ref_decode(awaddr_m[idx*32 +: 32]);
          end
        end
      end
      if (wroute_pop && old > 0) void'(q.pop_front());
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
